// File: rtl/coin_conditioner.sv
// coin_conditioner: synchronizes and debounces three coin-slot sensors, turns
// each accepted insertion into one coin code, buffers the codes in a small
// FIFO and presents them to the vending FSM as single-cycle pulses that are
// held back while the FSM is dispensing.
module coin_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DEPTH           = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sns_5,
    input  logic                       sns_10,
    input  logic                       sns_20,
    input  logic                       hold,
    output logic [1:0]                 coin_out,
    output logic                       reject,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic [7:0]                 reject_count
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               CNT_W    = $clog2(DEPTH + 1);
    localparam logic [7:0]       DB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);

    // Sensor bit i: 0 = 5 units, 1 = 10 units, 2 = 20 units.
    logic [2:0]       raw_s;
    logic [2:0]       sync1_r;
    logic [2:0]       sync2_r;
    logic [2:0]       deb_r;
    logic [7:0]       cnt_r [3];
    logic [2:0]       rise_s;
    logic [1:0]       ev_code_s;
    logic             single_s;
    logic             multi_s;
    logic             full_s;
    logic             pop_s;
    logic             push_s;
    logic             reject_s;
    logic [1:0]       mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;

    assign raw_s = {sns_20, sns_10, sns_5};

    // Two-flop synchronizer for the asynchronous sensor inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: the level only follows the synchronized input after it has
    // disagreed for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_r <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                cnt_r[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2_r[i] == deb_r[i]) begin
                    cnt_r[i] <= 8'd0;
                end else if (cnt_r[i] == DB_LAST) begin
                    deb_r[i] <= sync2_r[i];
                    cnt_r[i] <= 8'd0;
                end else begin
                    cnt_r[i] <= cnt_r[i] + 8'd1;
                end
            end
        end
    end

    // An insertion is the debounced level rising on this very edge, so the
    // FIFO write lands on the same edge as the deb 0->1 transition.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            rise_s[i] = sync2_r[i] & ~deb_r[i] & (cnt_r[i] == DB_LAST);
        end
    end

    // Resolve simultaneous insertions and decide push / pop / reject.
    always_comb begin
        ev_code_s = 2'b00;
        single_s  = 1'b0;
        multi_s   = 1'b0;
        case (rise_s)
            3'b000: begin
                single_s = 1'b0;
            end
            3'b001: begin
                single_s  = 1'b1;
                ev_code_s = 2'b01;
            end
            3'b010: begin
                single_s  = 1'b1;
                ev_code_s = 2'b10;
            end
            3'b100: begin
                single_s  = 1'b1;
                ev_code_s = 2'b11;
            end
            default: begin
                multi_s = 1'b1;
            end
        endcase

        full_s = (fifo_count == FULL_LVL);
        // Popping only when the previous output was 00 enforces the gap cycle.
        if ((coin_out == 2'b00) && (fifo_count != {CNT_W{1'b0}}) && !hold) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end

        if (single_s && (!full_s || pop_s)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end

        if (multi_s || (single_s && full_s && !pop_s)) begin
            reject_s = 1'b1;
        end else begin
            reject_s = 1'b0;
        end
    end

    // Coin FIFO storage, pointers (wrapping modulo DEPTH) and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            fifo_count <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 2'b00;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= ev_code_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Registered outputs: coin pulse, reject pulse and saturating reject tally.
    always_ff @(posedge clk) begin
        if (rst) begin
            coin_out     <= 2'b00;
            reject       <= 1'b0;
            reject_count <= 8'd0;
        end else begin
            coin_out <= pop_s ? mem_r[rd_ptr_r] : 2'b00;
            reject   <= reject_s;
            if (reject_s && (reject_count != 8'hFF)) begin
                reject_count <= reject_count + 8'd1;
            end else begin
                reject_count <= reject_count;
            end
        end
    end

endmodule

// File: tb/tb_coin_conditioner.sv
// Self-checking bench for coin_conditioner: directed scenarios followed by
// randomized bouncy insertions, compared every cycle against a queue-based
// reference model of the sensor-to-pulse behaviour.
module tb_coin_conditioner;

    localparam int D       = 16;
    localparam int DEPTH_P = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sns_5 = 1'b0;
    logic       sns_10 = 1'b0;
    logic       sns_20 = 1'b0;
    logic       hold = 1'b0;
    logic [1:0] coin_out;
    logic       reject;
    logic [2:0] fifo_count;
    logic [7:0] reject_count;

    coin_conditioner #(.DEBOUNCE_CYCLES(D), .DEPTH(DEPTH_P)) dut (
        .clk(clk), .rst(rst), .sns_5(sns_5), .sns_10(sns_10), .sns_20(sns_20),
        .hold(hold), .coin_out(coin_out), .reject(reject),
        .fifo_count(fifo_count), .reject_count(reject_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int m_sync1 [3];
    int m_s     [3];
    int m_deb   [3];
    int m_run   [3];
    int q [$];
    int m_coin = 0;
    int m_rej  = 0;
    int m_rcnt = 0;

    // Observation counters from the DUT.
    int pulses [4];
    int rej_seen = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at time %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock edge of the reference behaviour, using the inputs held before the edge.
    task automatic model_edge();
        int raw [3];
        int rises;
        int code;
        int head;
        int rej;
        raw[0] = int'(sns_5);
        raw[1] = int'(sns_10);
        raw[2] = int'(sns_20);
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_sync1[i] = 0; m_s[i] = 0; m_deb[i] = 0; m_run[i] = 0;
            end
            q.delete();
            m_coin = 0; m_rej = 0; m_rcnt = 0;
        end else begin
            rises = 0;
            code  = 0;
            // deb follows s once s has disagreed for D consecutive cycles
            for (int i = 0; i < 3; i++) begin
                if (m_s[i] != m_deb[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        if (m_s[i] == 1) begin
                            rises++;
                            code = i + 1;
                        end
                        m_deb[i] = m_s[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            for (int i = 0; i < 3; i++) begin
                m_s[i]     = m_sync1[i];
                m_sync1[i] = raw[i];
            end
            head = 0;
            if (m_coin == 0 && q.size() > 0 && !hold) begin
                head = q.pop_front();
            end
            rej = 0;
            if (rises > 1) begin
                rej = 1;
            end else if (rises == 1) begin
                if (q.size() < DEPTH_P) q.push_back(code);
                else rej = 1;
            end
            m_coin = head;
            m_rej  = rej;
            if (rej == 1 && m_rcnt < 255) m_rcnt++;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_eq("coin_out", int'(coin_out), m_coin);
        check_eq("reject", int'(reject), m_rej);
        check_eq("fifo_count", int'(fifo_count), q.size());
        check_eq("reject_count", int'(reject_count), m_rcnt);
        if (coin_out != 2'b00) pulses[coin_out]++;
        if (reject) rej_seen++;
    endtask

    task automatic drive(input logic [2:0] mask, input int n);
        {sns_20, sns_10, sns_5} = mask;
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic clean_coin(input int idx);
        drive(3'(1 << idx), D + 4);
        drive(3'b000, D + 4);
    endtask

    function automatic int total_pulses();
        return pulses[1] + pulses[2] + pulses[3];
    endfunction

    initial begin
        int found;
        int p0;
        int r0;
        int seq_exp [6];
        logic [2:0] mask;
        int sel;
        for (int i = 0; i < 4; i++) pulses[i] = 0;

        // Reset state
        rst = 1'b1;
        cycle();
        cycle();
        check_eq("rst_coin_out", int'(coin_out), 0);
        check_eq("rst_fifo_count", int'(fifo_count), 0);
        check_eq("rst_reject_count", int'(reject_count), 0);
        rst = 1'b0;

        // Clean 5-unit coin: pulse set at edge D+2
        found = -1;
        p0 = total_pulses();
        r0 = rej_seen;
        sns_5 = 1'b1;
        for (int e = 0; e < 40; e++) begin
            cycle();
            if (coin_out != 2'b00 && found < 0) found = e;
        end
        check_eq("first_pulse_edge", found, D + 2);
        check_eq("clean5_pulses", total_pulses() - p0, 1);
        check_eq("clean5_rejects", rej_seen - r0, 0);
        drive(3'b000, D + 4);

        // Bouncy 10-unit sensor
        p0 = pulses[2];
        r0 = rej_seen;
        drive(3'b010, 3); drive(3'b000, 2); drive(3'b010, 5); drive(3'b000, 1);
        drive(3'b010, 30);
        drive(3'b000, D + 4);
        check_eq("bounce10_pulses", pulses[2] - p0, 1);
        check_eq("bounce10_rejects", rej_seen - r0, 0);

        // Simultaneous 5 + 20
        p0 = total_pulses();
        r0 = rej_seen;
        drive(3'b101, D + 6);
        drive(3'b000, D + 4);
        check_eq("dual_pulses", total_pulses() - p0, 0);
        check_eq("dual_reject_pulses", rej_seen - r0, 1);
        check_eq("dual_reject_count", int'(reject_count), 1);

        // Accumulate under hold, then drain in insertion order
        hold = 1'b1;
        clean_coin(2); clean_coin(0); clean_coin(1);
        check_eq("hold_fifo_count", int'(fifo_count), 3);
        check_eq("hold_coin_out", int'(coin_out), 0);
        hold = 1'b0;
        seq_exp[0] = 3; seq_exp[1] = 0; seq_exp[2] = 1;
        seq_exp[3] = 0; seq_exp[4] = 2; seq_exp[5] = 0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            check_eq("drain_seq", int'(coin_out), seq_exp[k]);
        end
        check_eq("drain_empty", int'(fifo_count), 0);

        // Overflow: fifth coin under hold is rejected
        r0 = int'(reject_count);
        hold = 1'b1;
        for (int k = 0; k < 5; k++) clean_coin(k % 3);
        check_eq("ovf_reject_count", int'(reject_count) - r0, 1);
        check_eq("ovf_fifo_count", int'(fifo_count), DEPTH_P);
        p0 = total_pulses();
        hold = 1'b0;
        drive(3'b000, 20);
        check_eq("ovf_drain_pulses", total_pulses() - p0, DEPTH_P);

        // Reset mid-operation with two buffered coins and sns_10 mid-debounce
        hold = 1'b1;
        clean_coin(0); clean_coin(2);
        check_eq("pre_rst_fifo_count", int'(fifo_count), 2);
        drive(3'b010, 6);
        rst = 1'b1;
        hold = 1'b0;
        cycle();
        check_eq("midrst_coin_out", int'(coin_out), 0);
        check_eq("midrst_reject", int'(reject), 0);
        check_eq("midrst_fifo_count", int'(fifo_count), 0);
        check_eq("midrst_reject_count", int'(reject_count), 0);
        rst = 1'b0;
        found = -1;
        for (int e = 0; e < 40; e++) begin
            cycle();
            if (coin_out != 2'b00 && found < 0) begin
                found = e;
                check_eq("post_rst_code", int'(coin_out), 2);
            end
        end
        check_eq("post_rst_pulse_edge", found, D + 2);
        drive(3'b000, D + 4);

        // Randomized bouncy insertions, hold toggling and occasional resets
        for (int n = 0; n < 150; n++) begin
            hold = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 29) == 0) begin
                rst = 1'b1;
                cycle();
                rst = 1'b0;
            end
            sel = int'($urandom_range(0, 9));
            if (sel < 8) mask = 3'(1 << (sel % 3));
            else mask = 3'($urandom_range(3, 7));
            if (mask == 3'b100 && sel >= 8) mask = 3'b110;
            for (int b = 0; b < int'($urandom_range(0, 3)); b++) begin
                drive(mask, int'($urandom_range(1, D - 2)));
                drive(3'b000, int'($urandom_range(1, 4)));
            end
            drive(mask, D + int'($urandom_range(2, 10)));
            if ($urandom_range(0, 1) == 0) hold = ~hold;
            drive(3'b000, int'($urandom_range(D + 2, D + 12)));
        end
        hold = 1'b0;
        drive(3'b000, 30);
        check_eq("rand_drained", int'(fifo_count), 0);

        // reject_count saturation
        for (int k = 0; k < 260; k++) begin
            drive(3'b101, D + 3);
            drive(3'b000, D + 3);
        end
        check_eq("sat_reject_count", int'(reject_count), 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
